// File: rtl/graphics_pkg.sv
// Shared graphics types: vertex ids, 3-component vectors,
// the packed index record and the helper for the triangle counter.
package graphics_pkg;

  typedef logic [11:0]      vertex_id_t;
  typedef logic [2:0][31:0] vec3_t;
  typedef logic [2:0][11:0] index_t;

  localparam int IDX_POS = 2;
  localparam int IDX_NRM = 1;
  localparam int IDX_MAT = 0;

  // Next value of a mod-3 counter.
  function automatic logic [1:0] mod3_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/vertex_fetch.sv
// Walks the model index list and emits one assembled vertex
// (position, normal, material) per valid/ready handshake.
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   start_in, vertex_count_in frame start and vertex count
//   index_id_out / index_in  index BROM id and returned id triple
//   position/normal/material _id_out / _in  attribute memories
//   valid_out, ready_in      downstream handshake
//   position/normal/material_out, tri_last_out, frame_last_out
//   busy_out, done_out       frame status
module vertex_fetch
  import graphics_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  vertex_id_t vertex_count_in,
  output vertex_id_t index_id_out,
  input  index_t     index_in,
  output vertex_id_t position_id_out,
  input  vec3_t      position_in,
  output vertex_id_t normal_id_out,
  input  vec3_t      normal_in,
  output vertex_id_t material_id_out,
  input  vec3_t      material_in,
  output logic       valid_out,
  input  logic       ready_in,
  output vec3_t      position_out,
  output vec3_t      normal_out,
  output vec3_t      material_out,
  output logic       tri_last_out,
  output logic       frame_last_out,
  output logic       busy_out,
  output logic       done_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INDEX,
    S_ATTR,
    S_EMIT
  } state_t;

  localparam int WW = $clog2(READ_LATENCY + 1);
  // Memory data is valid READ_LATENCY cycles after the id is
  // presented, so each wait spans READ_LATENCY+1 cycles.
  localparam logic [WW-1:0] WAIT_LAST = WW'(READ_LATENCY);

  state_t     r_state;
  logic [WW-1:0] r_wait;
  vertex_id_t r_count;
  vertex_id_t r_vtx;
  logic [1:0] r_tri;

  vertex_id_t r_index_id;
  vertex_id_t r_pos_id;
  vertex_id_t r_nrm_id;
  vertex_id_t r_mat_id;
  logic       r_valid;
  vec3_t      r_pos;
  vec3_t      r_nrm;
  vec3_t      r_mat;
  logic       r_tri_last;
  logic       r_frame_last;
  logic       r_busy;
  logic       r_done;

  logic       w_wait_done;
  logic       w_last_vtx;

  assign w_wait_done = (r_wait == WAIT_LAST);
  assign w_last_vtx  = (r_vtx == r_count - 12'd1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_count      <= '0;
      r_vtx        <= '0;
      r_tri        <= '0;
      r_index_id   <= '0;
      r_pos_id     <= '0;
      r_nrm_id     <= '0;
      r_mat_id     <= '0;
      r_valid      <= 1'b0;
      r_pos        <= '0;
      r_nrm        <= '0;
      r_mat        <= '0;
      r_tri_last   <= 1'b0;
      r_frame_last <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_in) begin
            if (vertex_count_in != '0) begin
              r_count    <= vertex_count_in;
              r_vtx      <= '0;
              r_tri      <= '0;
              r_index_id <= '0;
              r_wait     <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_INDEX;
            end else begin
              // Empty frame completes immediately.
              r_done <= 1'b1;
            end
          end
        end
        S_INDEX: begin
          if (w_wait_done) begin
            r_wait   <= '0;
            r_pos_id <= index_in[IDX_POS];
            r_nrm_id <= index_in[IDX_NRM];
            r_mat_id <= index_in[IDX_MAT];
            r_state  <= S_ATTR;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_ATTR: begin
          if (w_wait_done) begin
            r_wait       <= '0;
            r_pos        <= position_in;
            r_nrm        <= normal_in;
            r_mat        <= material_in;
            r_tri_last   <= (r_tri == 2'd2);
            r_frame_last <= w_last_vtx;
            r_valid      <= 1'b1;
            r_state      <= S_EMIT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_EMIT: begin
          if (ready_in) begin
            r_valid <= 1'b0;
            if (w_last_vtx) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_vtx      <= r_vtx + 12'd1;
              r_index_id <= r_vtx + 12'd1;
              r_tri      <= mod3_inc(r_tri);
              r_state    <= S_INDEX;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign index_id_out    = r_index_id;
  assign position_id_out = r_pos_id;
  assign normal_id_out   = r_nrm_id;
  assign material_id_out = r_mat_id;
  assign valid_out       = r_valid;
  assign position_out    = r_pos;
  assign normal_out      = r_nrm;
  assign material_out    = r_mat;
  assign tri_last_out    = r_tri_last;
  assign frame_last_out  = r_frame_last;
  assign busy_out        = r_busy;
  assign done_out        = r_done;

endmodule
